pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller_pkg.sv | 20 ++
 rtl/pipeline_controller_forwarding.sv | 29 ++
 rtl/pipeline_controller.sv | 112 +++++++++++
 tb/tb_pipeline_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_controller_pkg.sv
// ============================================================================
// pipeline_controller_pkg : shared controller state and forwarding-select codes
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipeline_controller_pkg;

    typedef enum logic [0:0] {
        CTRL_RUN      = 1'b0,
        CTRL_MEM_WAIT = 1'b1
    } controller_state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/pipeline_controller_forwarding.sv
// ============================================================================
// forwarding_unit : selects the ALU operand source for one execute-stage source
// Revision: 1.0
// ============================================================================
`default_nettype none

module forwarding_unit
    import pipeline_controller_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       reg_w_en_m,
    input  logic [4:0] rd_w,
    input  logic       reg_w_en_w,
    output logic [1:0] fwd_sel
);

    // The memory stage holds the younger result, so it wins; x0 is hard-wired zero.
    always_comb begin
        fwd_sel = FWD_REG;
        if (reg_w_en_m && (rd_m != 5'd0) && (rd_m == rs))
            fwd_sel = FWD_M;
        else if (reg_w_en_w && (rd_w != 5'd0) && (rd_w == rs))
            fwd_sel = FWD_W;
    end

endmodule

`default_nettype wire

// File: rtl/pipeline_controller.sv
// ============================================================================
// pipeline_controller : hazard stall/flush control, forwarding, stall counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_controller
    import pipeline_controller_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  RS1_D,
    input  logic [4:0]  RS2_D,
    input  logic [4:0]  RS1_E,
    input  logic [4:0]  RS2_E,
    input  logic [4:0]  RD_E,
    input  logic [4:0]  RD_M,
    input  logic [4:0]  RD_W,
    input  logic        REG_W_En_M,
    input  logic        REG_W_En_W,
    input  logic        MEM_R_En_E,
    input  logic        PC_Src_Sel_E,
    input  logic        MEM_Req_M,
    input  logic        MEM_Ready,
    output logic        Stall_F,
    output logic        Stall_D,
    output logic        Stall_E,
    output logic        Stall_M,
    output logic        Flush_D,
    output logic        Flush_E,
    output logic        Flush_W,
    output logic [1:0]  Forward_A_Sel,
    output logic [1:0]  Forward_B_Sel,
    output logic [31:0] Stall_Cycles
);

    controller_state_t state;
    logic [31:0]       stall_count;
    logic              mem_wait;
    logic              load_use;

    forwarding_unit u_fwd_a (
        .rs         (RS1_E),
        .rd_m       (RD_M),
        .reg_w_en_m (REG_W_En_M),
        .rd_w       (RD_W),
        .reg_w_en_w (REG_W_En_W),
        .fwd_sel    (Forward_A_Sel)
    );

    forwarding_unit u_fwd_b (
        .rs         (RS2_E),
        .rd_m       (RD_M),
        .reg_w_en_m (REG_W_En_M),
        .rd_w       (RD_W),
        .reg_w_en_w (REG_W_En_W),
        .fwd_sel    (Forward_B_Sel)
    );

    assign mem_wait = MEM_Req_M && !MEM_Ready;
    assign load_use = MEM_R_En_E && (RD_E != 5'd0) &&
                      ((RD_E == RS1_D) || (RD_E == RS2_D));

    // Priority: reset, memory wait, taken control flow, load-use.
    always_comb begin
        Stall_F = 1'b0;
        Stall_D = 1'b0;
        Stall_E = 1'b0;
        Stall_M = 1'b0;
        Flush_D = 1'b0;
        Flush_E = 1'b0;
        Flush_W = 1'b0;
        if (RST) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
            Flush_W = 1'b1;
        end else if (mem_wait) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Stall_M = 1'b1;
            Flush_W = 1'b1;
        end else if (PC_Src_Sel_E) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
        end else if (load_use) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Flush_E = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= CTRL_RUN;
            stall_count <= 32'd0;
        end else begin
            case (state)
                CTRL_RUN:      if (mem_wait)  state <= CTRL_MEM_WAIT;
                CTRL_MEM_WAIT: if (MEM_Ready) state <= CTRL_RUN;
                default:                      state <= CTRL_RUN;
            endcase
            if (Stall_F && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
        end
    end

    assign Stall_Cycles = stall_count;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_controller.sv
// ============================================================================
// tb_pipeline_controller : rule-based model plus directed hand-computed checks
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_controller;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
    logic        REG_W_En_M, REG_W_En_W, MEM_R_En_E, PC_Src_Sel_E, MEM_Req_M, MEM_Ready;
    logic        Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W;
    logic [1:0]  Forward_A_Sel, Forward_B_Sel;
    logic [31:0] Stall_Cycles;

    int          tests = 0;
    int          fails = 0;
    bit          checking = 1'b0;
    logic [31:0] m_count;

    always #5 CLK = ~CLK;

    pipeline_controller dut (
        .CLK(CLK), .RST(RST),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
        .RD_M(RD_M), .RD_W(RD_W), .REG_W_En_M(REG_W_En_M), .REG_W_En_W(REG_W_En_W),
        .MEM_R_En_E(MEM_R_En_E), .PC_Src_Sel_E(PC_Src_Sel_E),
        .MEM_Req_M(MEM_Req_M), .MEM_Ready(MEM_Ready),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
        .Forward_A_Sel(Forward_A_Sel), .Forward_B_Sel(Forward_B_Sel),
        .Stall_Cycles(Stall_Cycles)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: source number 2 = memory stage, 1 = writeback, 0 = register file.
    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (rs == 5'd0)                                return 2'd0;
        if (REG_W_En_M && RD_M == rs)                  return 2'd2;
        if (REG_W_En_W && RD_W == rs)                  return 2'd1;
        return 2'd0;
    endfunction

    // Model: {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W}
    function automatic logic [6:0] m_ctrl();
        logic mw, lu, br;
        mw = MEM_Req_M && !MEM_Ready;
        lu = MEM_R_En_E && RD_E != 5'd0 && (RD_E == RS1_D || RD_E == RS2_D);
        br = PC_Src_Sel_E;
        if (RST) return 7'b0000_111;
        return {mw || (lu && !br), mw || (lu && !br), mw, mw,
                !mw && br, !mw && (br || lu), mw};
    endfunction

    always @(posedge CLK) begin
        if (RST)                                           m_count = 32'd0;
        else if (m_ctrl() >> 6 && m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    end

    always @(negedge CLK) begin
        if (checking) begin
            check("model_fwd_a", {30'd0, Forward_A_Sel}, {30'd0, m_fwd(RS1_E)});
            check("model_fwd_b", {30'd0, Forward_B_Sel}, {30'd0, m_fwd(RS2_E)});
            check("model_ctrl",
                  {25'd0, Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W},
                  {25'd0, m_ctrl()});
            check("model_count", Stall_Cycles, m_count);
        end
    end

    task automatic clear();
        {RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W} = '0;
        {REG_W_En_M, REG_W_En_W, MEM_R_En_E, PC_Src_Sel_E, MEM_Req_M, MEM_Ready} = '0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic ctrl_is(input string name, input logic [6:0] exp);
        @(negedge CLK);
        check(name, {25'd0, Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W},
              {25'd0, exp});
    endtask

    initial begin
        RST = 1'b1;
        clear();
        step();
        checking = 1'b1;
        ctrl_is("reset_flush", 7'b0000_111);
        check("reset_count", Stall_Cycles, 32'd0);
        step();
        RST = 1'b0;

        // Forwarding: M over W, x0 never forwarded, W-only match
        RD_M = 5'd5; REG_W_En_M = 1'b1; RD_W = 5'd5; REG_W_En_W = 1'b1; RS1_E = 5'd5;
        @(negedge CLK);
        check("fwd_m_priority", {30'd0, Forward_A_Sel}, 32'd2);
        step();
        RD_M = 5'd0; RS1_E = 5'd0; RD_W = 5'd0;
        @(negedge CLK);
        check("fwd_x0", {30'd0, Forward_A_Sel}, 32'd0);
        step();
        RD_M = 5'd3; RD_W = 5'd9; RS2_E = 5'd9;
        @(negedge CLK);
        check("fwd_w_only", {30'd0, Forward_B_Sel}, 32'd1);
        step();
        clear();

        // Load-use: one bubble, counter 0 -> 1
        MEM_R_En_E = 1'b1; RD_E = 5'd7; RS2_D = 5'd7;
        ctrl_is("load_use", 7'b1100_010);
        check("load_use_cnt_before", Stall_Cycles, 32'd0);
        step();
        clear();
        ctrl_is("after_load_use", 7'b0000_000);
        check("load_use_cnt_after", Stall_Cycles, 32'd1);

        // Load-use suppressed by taken branch
        step();
        MEM_R_En_E = 1'b1; RD_E = 5'd7; RS2_D = 5'd7; PC_Src_Sel_E = 1'b1;
        ctrl_is("branch_over_lu", 7'b0000_110);
        step();
        clear();
        @(negedge CLK);
        check("branch_cnt_same", Stall_Cycles, 32'd1);

        // Memory wait with branch held in execute, from a clean counter
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            MEM_Req_M = 1'b1; MEM_Ready = 1'b0; PC_Src_Sel_E = 1'b1;
            ctrl_is("mem_wait", 7'b1111_001);
            step();
        end
        MEM_Ready = 1'b1;
        ctrl_is("mem_ready_flush", 7'b0000_110);
        check("mem_wait_cnt", Stall_Cycles, 32'd3);
        step();
        clear();

        // Reset during memory wait
        MEM_Req_M = 1'b1;
        step();
        RST = 1'b1;
        ctrl_is("rst_in_wait", 7'b0000_111);
        step();
        @(negedge CLK);
        check("rst_in_wait_cnt", Stall_Cycles, 32'd0);
        step();
        RST = 1'b0;
        clear();
        ctrl_is("after_rst_idle", 7'b0000_000);

        // Saturation
        step();
        MEM_Req_M = 1'b1;
        force dut.stall_count = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        #1 release dut.stall_count;
        @(negedge CLK);
        check("sat_forced", Stall_Cycles, 32'hFFFF_FFFF);
        step();
        @(negedge CLK);
        check("sat_hold", Stall_Cycles, 32'hFFFF_FFFF);
        step();
        clear();

        // Sweep of mixed patterns checked by the model
        for (int i = 0; i < 48; i++) begin
            logic [7:0] v;
            v = 8'(i * 37 + 11);
            RS1_E = {2'b0, v[2:0]};  RS2_E = {2'b0, v[5:3]};
            RD_M = {2'b0, v[4:2]};   RD_W = {2'b0, v[7:5]};
            REG_W_En_M = v[0];       REG_W_En_W = v[1];
            RS1_D = {2'b0, v[3:1]};  RS2_D = {2'b0, v[6:4]};  RD_E = {2'b0, v[2:0]};
            MEM_R_En_E = v[6];       PC_Src_Sel_E = (v[3:1] == 3'd5);
            MEM_Req_M = v[7];        MEM_Ready = v[2];
            RST = (i == 30);
            step();
        end
        RST = 1'b0;
        clear();
        step();
        @(negedge CLK);
        checking = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
